channel_bank: RTL

Architectural state behind `commit_master`: a 16-entry channel register file plus the 2×data_width MAC accumulator. It absorbs the commit stage's channel and accumulator write strobes, serves registered read ports to the instruction branches with same-edge write bypass, and exposes a shifted, saturated accumulator readout. On each `sample_tick` it latches the designated output channel as the block's per-sample audio output.

---
 rtl/channel_bank_pkg.sv | 14 +
 rtl/acc_saturate.sv | 33 +++
 rtl/channel_bank.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/channel_bank_pkg.sv
// rtl/channel_bank_pkg.sv - shared constants for the channel bank
//
// Purpose: address width and well-known channel numbers shared by the
// commit stage and the channel register file.
//   CHANNEL_ADDR_WIDTH : width of every channel address port
//   SAMPLE_IN_CHANNEL  : channel fed by the sample input path
//   OUT_CHANNEL        : default channel latched as the per-sample output
package channel_bank_pkg;

  localparam int CHANNEL_ADDR_WIDTH = 4;
  localparam int SAMPLE_IN_CHANNEL  = 0;
  localparam int OUT_CHANNEL        = 1;

endpackage

// File: rtl/acc_saturate.sv
// rtl/acc_saturate.sv - arithmetic right shift plus signed clamp of the accumulator
//
// Purpose: purely combinational readout path; the caller registers sat_val.
// Ports:
//   acc_val : in  2*data_width  accumulator value (two's complement)
//   shift   : in  5             arithmetic right shift amount
//   sat_val : out data_width    shifted value clamped to the signed data_width range
module acc_saturate #(
  parameter int data_width = 16
) (
  input  logic [2*data_width-1:0] acc_val,
  input  logic [4:0]              shift,
  output logic [data_width-1:0]   sat_val
);

  localparam int AW = 2 * data_width;

  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted = $signed(acc_val) >>> shift;
    // The value fits in data_width bits only when every bit from the
    // data_width sign position upward equals the overall sign bit.
    if (!shifted[AW-1] && (|shifted[AW-2:data_width-1])) begin
      sat_val = {1'b0, {(data_width-1){1'b1}}};
    end else if (shifted[AW-1] && !(&shifted[AW-2:data_width-1])) begin
      sat_val = {1'b1, {(data_width-1){1'b0}}};
    end else begin
      sat_val = shifted[data_width-1:0];
    end
  end

endmodule

// File: rtl/channel_bank.sv
// rtl/channel_bank.sv - channel register file and MAC accumulator behind the commit stage
//
// Purpose: holds the 16 channel registers and the double-width accumulator,
// serves two registered write-first read ports, a registered shifted and
// saturated accumulator readout, and latches the output channel per sample.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   enable                    : gates writes, accumulator and sample capture
//   sample_tick               : one-cycle sample strobe
//   channel_write_*           : channel write address / data / strobe
//   accumulator_write_*       : accumulator operand / strobe
//   accumulator_add_enable    : 1 = accumulate, 0 = load
//   read_addr_a/b, read_val_a/b : registered read ports
//   acc_shift, acc_sat        : readout shift and registered saturated result
//   acc_raw                   : accumulator register
//   acc_overflow              : sticky signed overflow of accumulate
//   sample_out(_valid)        : latched output sample and its one-cycle pulse
module channel_bank
  import channel_bank_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int n_channels  = 16,
  parameter int out_channel = OUT_CHANNEL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sample_tick,
  input  logic [CHANNEL_ADDR_WIDTH-1:0] channel_write_addr,
  input  logic [data_width-1:0]         channel_write_val,
  input  logic                          channel_write_enable,
  input  logic [2*data_width-1:0]       accumulator_write_val,
  input  logic                          accumulator_write_enable,
  input  logic                          accumulator_add_enable,
  input  logic [CHANNEL_ADDR_WIDTH-1:0] read_addr_a,
  input  logic [CHANNEL_ADDR_WIDTH-1:0] read_addr_b,
  output logic [data_width-1:0]         read_val_a,
  output logic [data_width-1:0]         read_val_b,
  input  logic [4:0]                    acc_shift,
  output logic [2*data_width-1:0]       acc_raw,
  output logic [data_width-1:0]         acc_sat,
  output logic                          acc_overflow,
  output logic [data_width-1:0]         sample_out,
  output logic                          sample_out_valid
);

  localparam int AW = 2 * data_width;
  localparam logic [CHANNEL_ADDR_WIDTH-1:0] OUT_IDX = CHANNEL_ADDR_WIDTH'(out_channel);

  logic [data_width-1:0] ch_q [n_channels];
  logic [data_width-1:0] ch_d [n_channels];
  logic [AW-1:0]         acc_q, acc_d;
  logic                  acc_overflow_q, acc_overflow_d;
  logic [data_width-1:0] read_val_a_q, read_val_a_d;
  logic [data_width-1:0] read_val_b_q, read_val_b_d;
  logic [data_width-1:0] acc_sat_q, acc_sat_d;
  logic [data_width-1:0] sample_out_q, sample_out_d;
  logic                  sample_out_valid_q, sample_out_valid_d;

  logic                  ch_wr;
  logic                  acc_wr;
  logic [AW-1:0]         acc_sum;
  logic [data_width-1:0] sat_val;

  assign ch_wr   = enable && channel_write_enable;
  assign acc_wr  = enable && accumulator_write_enable;
  assign acc_sum = acc_q + accumulator_write_val;

  // Saturation works on the post-update accumulator so acc_sat lines up
  // with acc_raw on the cycle after the strobe.
  acc_saturate #(
    .data_width(data_width)
  ) u_acc_saturate (
    .acc_val(acc_d),
    .shift  (acc_shift),
    .sat_val(sat_val)
  );

  always_comb begin
    ch_d = ch_q;
    if (ch_wr) begin
      ch_d[channel_write_addr] = channel_write_val;
    end

    acc_d          = acc_q;
    acc_overflow_d = acc_overflow_q;
    if (acc_wr) begin
      if (accumulator_add_enable) begin
        acc_d = acc_sum;
        // Same-sign operands producing an opposite-sign result wrapped.
        if ((acc_q[AW-1] == accumulator_write_val[AW-1]) &&
            (acc_sum[AW-1] != acc_q[AW-1])) begin
          acc_overflow_d = 1'b1;
        end
      end else begin
        acc_d = accumulator_write_val;
      end
    end

    acc_sat_d = sat_val;

    // Write-first: a same-edge write to the read address wins.
    read_val_a_d = (ch_wr && channel_write_addr == read_addr_a) ?
                   channel_write_val : ch_q[read_addr_a];
    read_val_b_d = (ch_wr && channel_write_addr == read_addr_b) ?
                   channel_write_val : ch_q[read_addr_b];

    // Capture sees the pre-edge channel value, never the bypass.
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    if (enable && sample_tick) begin
      sample_out_d       = ch_q[OUT_IDX];
      sample_out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < n_channels; i++) begin
        ch_q[i] <= '0;
      end
      acc_q              <= '0;
      acc_overflow_q     <= 1'b0;
      acc_sat_q          <= '0;
      read_val_a_q       <= '0;
      read_val_b_q       <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
    end else begin
      ch_q               <= ch_d;
      acc_q              <= acc_d;
      acc_overflow_q     <= acc_overflow_d;
      acc_sat_q          <= acc_sat_d;
      read_val_a_q       <= read_val_a_d;
      read_val_b_q       <= read_val_b_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
    end
  end

  assign read_val_a       = read_val_a_q;
  assign read_val_b       = read_val_b_q;
  assign acc_raw          = acc_q;
  assign acc_sat          = acc_sat_q;
  assign acc_overflow     = acc_overflow_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;

endmodule
